rom_burst: RTL and testbench

Parametrised synchronous constant ROM with a burst read engine, the successor to the fixed 16×32 combinational lookup in the ALU datapath. A single start request streams a run of consecutive words, with address wrap-around, to the ALU operand path over a valid/ready handshake with backpressure. The same block also serves as an operand/constant source for ALU test sequences.

---
 rtl/rom_burst_if.sv | 38 +++
 rtl/rom_burst.sv | 110 +++++++++++
 tb/tb_rom_burst.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rom_burst_if.sv
// Handshake bundle between the rom_burst engine and its consumer.
// par_o is present only when ROM_PARITY_EN is defined.
interface rom_burst_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              start_i;
  logic [ADDR_W-1:0] dir_i;
  logic [ADDR_W:0]   len_i;
  logic              abort_i;
  logic              ready_i;
  logic [DATA_W-1:0] sal_o;
  logic              valid_o;
  logic              last_o;
  logic              busy_o;
  logic              done_o;
`ifdef ROM_PARITY_EN
  logic              par_o;

  modport master (
    output start_i, dir_i, len_i, abort_i, ready_i,
    input  sal_o, valid_o, last_o, busy_o, done_o, par_o
  );
  modport slave (
    input  start_i, dir_i, len_i, abort_i, ready_i,
    output sal_o, valid_o, last_o, busy_o, done_o, par_o
  );
`else
  modport master (
    output start_i, dir_i, len_i, abort_i, ready_i,
    input  sal_o, valid_o, last_o, busy_o, done_o
  );
  modport slave (
    input  start_i, dir_i, len_i, abort_i, ready_i,
    output sal_o, valid_o, last_o, busy_o, done_o
  );
`endif
endinterface

// File: rtl/rom_burst.sv
// Constant ROM with a burst read engine streaming consecutive words (wrapping) over valid/ready.
// Optional registered even-parity output par_o when ROM_PARITY_EN is defined.
module rom_burst #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  rom_burst_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] REM_TWO = (ADDR_W+1)'(2);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   rem;
  logic [ADDR_W-1:0] ptr_nxt;

  // Natural ADDR_W-bit overflow gives the DEPTH-1 -> 0 wrap.
  assign ptr_nxt = ptr + 1'b1;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [3:0]  idx;
    logic [31:0] w;
    idx = 4'(a);
    case (idx)
      4'd0:    w = 32'h00000001;
      4'd1:    w = 32'h777ABCFE;
      4'd2:    w = 32'h48151623;
      4'd3:    w = 32'hFEDCBA98;
      4'd4:    w = 32'hAABBCCDD;
      4'd5:    w = 32'hFC963011;
      4'd6:    w = 32'h02468ACE;
      4'd7:    w = 32'h39992AAF;
      4'd8:    w = 32'h88FFADCA;
      4'd9:    w = 32'hFFAA9911;
      4'd10:   w = 32'h88925378;
      4'd11:   w = 32'hABBDFF89;
      4'd12:   w = 32'hFFFA8524;
      4'd13:   w = 32'h3628162B;
      4'd14:   w = 32'h8376A9CB;
      default: w = 32'hFFFFFFFF;
    endcase
    return DATA_W'(w);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      rem         <= '0;
      bus.sal_o   <= '0;
      bus.valid_o <= 1'b0;
      bus.last_o  <= 1'b0;
      bus.busy_o  <= 1'b0;
      bus.done_o  <= 1'b0;
`ifdef ROM_PARITY_EN
      bus.par_o   <= 1'b0;
`endif
    end else begin
      bus.done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_i && (bus.len_i != '0)) begin
            state       <= BURST;
            ptr         <= bus.dir_i;
            rem         <= bus.len_i;
            bus.sal_o   <= rom_word(bus.dir_i);
            bus.valid_o <= 1'b1;
            bus.last_o  <= (bus.len_i == REM_ONE);
            bus.busy_o  <= 1'b1;
`ifdef ROM_PARITY_EN
            bus.par_o   <= ^rom_word(bus.dir_i);
`endif
          end
        end
        BURST: begin
          // Abort wins over a transfer in the same cycle; the beat is dropped.
          if (bus.abort_i) begin
            state       <= IDLE;
            bus.valid_o <= 1'b0;
            bus.last_o  <= 1'b0;
            bus.busy_o  <= 1'b0;
          end else if (bus.valid_o && bus.ready_i) begin
            if (rem == REM_ONE) begin
              state       <= IDLE;
              bus.valid_o <= 1'b0;
              bus.last_o  <= 1'b0;
              bus.busy_o  <= 1'b0;
              bus.done_o  <= 1'b1;
            end else begin
              ptr        <= ptr_nxt;
              rem        <= rem - REM_ONE;
              bus.sal_o  <= rom_word(ptr_nxt);
              bus.last_o <= (rem == REM_TWO);
`ifdef ROM_PARITY_EN
              bus.par_o  <= ^rom_word(ptr_nxt);
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst.sv
// Scoreboard bench for rom_burst: accepted bursts push expected beats, a negedge monitor pops and checks.
// Set ROM_PARITY_EN to also check par_o.
module tb_rom_burst;
  parameter int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2**ADDR_W;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  rom_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  logic [31:0] table_t [16] = '{
    32'h00000001, 32'h777ABCFE, 32'h48151623, 32'hFEDCBA98,
    32'hAABBCCDD, 32'hFC963011, 32'h02468ACE, 32'h39992AAF,
    32'h88FFADCA, 32'hFFAA9911, 32'h88925378, 32'hABBDFF89,
    32'hFFFA8524, 32'h3628162B, 32'h8376A9CB, 32'hFFFFFFFF};

  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0;
  bit    busy_m = 1'b0;
  bit    done_m = 1'b0;
  beat_t exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_word(input int addr);
    return DATA_W'(table_t[(addr % DEPTH) % 16]);
  endfunction

  // Monitor: check outputs for the current cycle, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 64'(bus.busy_o), 64'(busy_m));
      chk("done", 64'(bus.done_o), 64'(done_m));
      chk("valid", 64'(bus.valid_o), 64'(busy_m));
      if (bus.valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat: unexpected beat %h, expected none", bus.sal_o);
        end else begin
          chk("data", 64'(bus.sal_o), 64'(exp_q[0].data));
          chk("last", 64'(bus.last_o), 64'(exp_q[0].last));
`ifdef ROM_PARITY_EN
          chk("par", 64'(bus.par_o), 64'(^exp_q[0].data));
`endif
        end
      end
      done_m = 1'b0;
      if (busy_m) begin
        if (bus.abort_i) begin
          exp_q.delete();
          busy_m = 1'b0;
        end else if (bus.ready_i) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            busy_m = 1'b0;
            done_m = 1'b1;
          end
        end
      end else if (bus.start_i && bus.len_i != 0) begin
        for (int k = 0; k < int'(bus.len_i); k++)
          exp_q.push_back('{data: exp_word(int'(bus.dir_i) + k), last: (k == int'(bus.len_i) - 1)});
        busy_m = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int dir, input int len);
    bus.start_i = 1'b1;
    bus.dir_i   = ADDR_W'(dir);
    bus.len_i   = (ADDR_W+1)'(len);
    cyc();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((busy_m || done_m) && n < max_cyc) begin
      cyc();
      n++;
    end
    total++;
    if (n >= max_cyc) begin
      bad++;
      $display("FAIL timeout: burst still active after %0d cycles", n);
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.dir_i   = '0;
    bus.len_i   = '0;
    bus.abort_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (3) cyc();
    chk("rst_sal", 64'(bus.sal_o), 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_last", 64'(bus.last_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
`ifdef ROM_PARITY_EN
    chk("rst_par", 64'(bus.par_o), 64'd0);
`endif
    rst = 1'b0;
    mon_en = 1'b1;
    cyc();

    start_burst(0, 1);
    wait_idle(20);

    start_burst(14, 4);
    wait_idle(20);

    start_burst(3, 3);
    cyc();
    bus.ready_i = 1'b0;
    repeat (3) cyc();
    bus.ready_i = 1'b1;
    wait_idle(20);

    start_burst(0, 8);
    cyc();
    bus.abort_i = 1'b1;
    cyc();
    bus.abort_i = 1'b0;
    start_burst(9, 1);
    wait_idle(20);

    start_burst(5, 0);
    cyc();
    start_burst(2, 6);
    cyc();
    start_burst(7, 3);
    wait_idle(40);

    start_burst(15, 20);
    wait_idle(40);

    // Asynchronous reset mid-burst.
    start_burst(0, 10);
    cyc();
    cyc();
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.valid_o), 64'd0);
    chk("arst_busy", 64'(bus.busy_o), 64'd0);
    chk("arst_done", 64'(bus.done_o), 64'd0);
    busy_m = 1'b0;
    done_m = 1'b0;
    exp_q.delete();
    cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    cyc();

    for (int i = 0; i < 600; i++) begin
      bus.start_i = ($urandom % 4) == 0;
      bus.dir_i   = ADDR_W'($urandom);
      bus.len_i   = (ADDR_W+1)'($urandom_range(0, 20));
      bus.ready_i = ($urandom % 4) != 0;
      bus.abort_i = ($urandom % 40) == 0;
      cyc();
    end
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.ready_i = 1'b1;
    wait_idle(100);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
